// File: rtl/accept_tally_counter.sv
// accept_tally_counter: gated, edge-qualified up/down tally with saturate/wrap at MAX and registered overflow/underflow pulses
module accept_tally_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4,
  parameter bit WRAP  = 1'b0,
  parameter bit EDGE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             select,
  input  logic             accepted,
  input  logic             refund,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  if (MAX < 1 || MAX > (2**WIDTH) - 1) begin : g_bad_max
    $error("accept_tally_counter: MAX out of range for WIDTH");
  end
  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MAX);
  logic [WIDTH-1:0] r_count;
  logic             r_acc_q, r_ref_q, r_ovf, r_unf;
  logic             w_en, w_inc, w_dec, w_up, w_down, w_at_max, w_at_zero;
  logic [WIDTH-1:0] w_next;
  assign w_en      = select & ~d;
  assign w_inc     = w_en & accepted & ~(EDGE & r_acc_q);
  assign w_dec     = w_en & refund & ~(EDGE & r_ref_q);
  assign w_up      = w_inc & ~w_dec;
  assign w_down    = w_dec & ~w_inc;
  // anything above MAX is treated as MAX so a forced bad value recovers
  assign w_at_max  = r_count >= W_MAX;
  assign w_at_zero = r_count == '0;
  always_comb begin
    w_next = r_count;
    if (w_up)
      w_next = w_at_max ? (WRAP ? '0 : W_MAX) : r_count + 1'b1;
    else if (w_down)
      w_next = w_at_zero ? (WRAP ? W_MAX : '0) : r_count - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_acc_q <= 1'b0;
      r_ref_q <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_acc_q <= accepted;
      r_ref_q <= refund;
      r_count <= clear ? '0 : w_next;
      r_ovf   <= ~clear & w_up & w_at_max;
      r_unf   <= ~clear & w_down & w_at_zero;
    end
  end
  assign count     = r_count;
  assign full      = r_count == W_MAX;
  assign empty     = r_count == '0;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule
